// File: rtl/cga_fetch_reader.sv
// CGA read initiator: walks the frame memory line by line, buffers the returned
// bytes in a small prefetch FIFO and hands them to the pixel serializer on request.
module cga_fetch_reader #(
    parameter int unsigned LINE_BYTES = 80,
    parameter int unsigned LINES      = 200,
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        line_start,
    output logic [15:0] aCga,
    input  logic [7:0]  dCga,
    input  logic        rd_ack,
    input  logic        byte_req,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    output logic        underrun
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LINE_STEP = 16'(LINE_BYTES);
    localparam logic [7:0]  LINE_CNT  = 8'(LINE_BYTES);
    localparam logic [10:0] LINES_W   = 11'(LINES);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_BLANK
    } state_t;

    state_t        r_state;
    logic [15:0]   r_acga;
    logic [15:0]   r_line_base;
    logic [10:0]   r_line_idx;
    logic [7:0]    r_fetch_cnt;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_pix_data;
    logic          r_pix_valid;
    logic          r_underrun;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_line_adv;
    logic          w_underrun_evt;
    logic [10:0]   w_next_idx;
    logic [15:0]   w_next_base;
    logic [AW:0]   w_count_next;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_pop       = byte_req && !w_empty;
    // A full FIFO still accepts the byte when a pop frees a slot in the same cycle.
    assign w_push      = (r_state == S_FETCH) && rd_ack && (!w_full || byte_req)
                         && !frame_start && !line_start;
    assign w_line_adv  = line_start && !frame_start && (r_state != S_IDLE);
    assign w_underrun_evt = byte_req && w_empty
                         && ((r_state == S_FETCH) || (r_state == S_DRAIN));
    assign w_next_idx  = r_line_idx + 11'd1;
    assign w_next_base = r_line_base + LINE_STEP;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: the storage array is not reset; pointers and count are, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dCga;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_acga      <= BASE_ADDR;
            r_line_base <= BASE_ADDR;
            r_line_idx  <= '0;
            r_fetch_cnt <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pix_data  <= 8'h00;
            r_pix_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_pix_valid <= byte_req;
            r_pix_data  <= w_pop ? r_mem[r_rd_ptr] : 8'h00;
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end

            if (frame_start) begin
                r_state     <= S_FETCH;
                r_acga      <= BASE_ADDR;
                r_line_base <= BASE_ADDR;
                r_line_idx  <= '0;
                r_fetch_cnt <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_underrun  <= 1'b0;
            end else if (w_line_adv) begin
                r_state     <= (w_next_idx < LINES_W) ? S_FETCH : S_BLANK;
                r_acga      <= w_next_base;
                r_line_base <= w_next_base;
                // Saturate once past the last line so repeated blanking pulses cannot wrap back into FETCH.
                if (r_line_idx < LINES_W) begin
                    r_line_idx <= w_next_idx;
                end
                r_fetch_cnt <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr    <= r_wr_ptr + 1'b1;
                    r_acga      <= r_acga + 16'd1;
                    r_fetch_cnt <= r_fetch_cnt + 8'd1;
                    if ((r_fetch_cnt + 8'd1) == LINE_CNT) begin
                        r_state <= S_DRAIN;
                    end
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_next;
            end
        end
    end

    assign aCga      = r_acga;
    assign pix_data  = r_pix_data;
    assign pix_valid = r_pix_valid;
    assign underrun  = r_underrun;

endmodule

// File: doc/cga_fetch_reader.md
Name: cga_fetch_reader

Overview:
CGA-side read initiator for the scan-converter frame memory. It is the client that the memory arbiter serves on its read slots. Per display line it generates sequential byte addresses on aCga and captures the returned dCga bytes into a small prefetch FIFO. It then delivers one byte per consumer request to the CGA pixel serializer. Line and frame sequencing come from the CGA timing generator.

Parameters:
LINE_BYTES, 80, bytes fetched per active line (1..255)
LINES, 200, active lines per frame (1..1023)
BASE_ADDR, 16'h0000, memory address of byte 0 of line 0
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, 2..16)

Ports:
clk  in  1  system clock, same clock as the memory arbiter
reset  in  1  synchronous, active-high; sampled on rising clk
frame_start  in  1  one-cycle pulse; starts a frame and fetch of line 0
line_start  in  1  one-cycle pulse; advances to the next line
aCga  out  16  read address presented to the memory arbiter
dCga  in  8  read data from the arbiter
rd_ack  in  1  one-cycle pulse: dCga holds the byte for the current aCga
byte_req  in  1  consumer pops one byte (pulse)
pix_data  out  8  byte delivered to the serializer
pix_valid  out  1  one-cycle pulse qualifying pix_data
underrun  out  1  sticky flag: a pop found the FIFO empty during an active line

Behaviour:
- Reset (synchronous, active-high): state=IDLE; aCga=BASE_ADDR; line_base=BASE_ADDR; line_idx=0; fetch_cnt=0; FIFO empty; pix_data=8'h00; pix_valid=0; underrun=0.
- States:
  - IDLE: no fetch.
  - FETCH: line active, bytes outstanding.
  - DRAIN: all LINE_BYTES fetched; FIFO still popping.
  - BLANK: line_idx>=LINES; no fetch.
- frame_start:
  - line_base<=BASE_ADDR, line_idx<=0, aCga<=BASE_ADDR, fetch_cnt<=0.
  - FIFO flushed, underrun<=0, state<=FETCH.
  - Applies from any state.
- line_start (without frame_start):
  - line_base<=line_base+LINE_BYTES, line_idx<=line_idx+1, aCga<=line_base+LINE_BYTES, fetch_cnt<=0, FIFO flushed.
  - state<=FETCH if line_idx+1<LINES, else BLANK.
  - Ignored in IDLE.
  - If frame_start and line_start coincide, frame_start wins.
- FETCH:
  - aCga is held stable until rd_ack.
  - On rd_ack with FIFO not full (or full with a simultaneous pop), push dCga, aCga<=aCga+1, fetch_cnt<=fetch_cnt+1.
  - When fetch_cnt reaches LINE_BYTES, state<=DRAIN.
  - rd_ack with FIFO full and no pop: byte discarded; aCga and fetch_cnt unchanged, so the same address is re-read on the next ack.
- rd_ack outside FETCH: ignored.
- Address arithmetic: 16-bit, wraps 16'hFFFF -> 16'h0000. line_base wraps likewise.
- Pop: byte_req in the cycle after a request gives pix_valid=1 and pix_data = FIFO head (1-cycle latency); the FIFO pops.
- byte_req with FIFO empty:
  - pix_valid=1, pix_data=8'h00.
  - In FETCH/DRAIN, underrun<=1; it stays set until frame_start or reset.
  - In BLANK/IDLE, underrun is not set.
- Simultaneous push and pop: both occur and the occupancy count is unchanged. Pop sees the pre-push head; an empty FIFO pops 8'h00 that cycle.
- pix_valid is 0 in every cycle without a preceding byte_req.
- Reset mid-fetch: all state is cleared immediately and no stale FIFO data is ever output.

Test Plan:
1. LINE_BYTES=4, BASE_ADDR=16'h1000. reset, then frame_start; rd_ack each time aCga changes, dCga=aCga[7:0] -> aCga steps 1000,1001,1002,1003; state DRAIN; 4 byte_req give pix_data 00,01,02,03, each a 1-cycle pulse.
2. FIFO_DEPTH=4, LINE_BYTES=8. Give 6 rd_ack with no byte_req -> FIFO holds 4 bytes; aCga=1004 and held; ack 5 and 6 discarded. Pop once, then ack -> byte 04 pushed; aCga=1005.
3. frame_start then line_start x2, LINE_BYTES=80, BASE_ADDR=0 -> aCga=160 (16'h00A0) at the start of line 2; FIFO flushed at each line_start.
4. LINES=2. frame_start, then line_start x2 -> state BLANK; rd_ack ignored; byte_req gives pix_data=00, pix_valid=1, underrun stays 0.
5. byte_req in FETCH with FIFO empty -> pix_data=00, underrun=1. underrun is held across line_start; frame_start clears it.
6. BASE_ADDR=16'hFFFE, LINE_BYTES=4 -> aCga FFFE,FFFF,0000,0001. Assert reset mid-line -> next cycle aCga=FFFE, pix_valid=0, FIFO empty.
